cnet_reg_arbiter: RTL and testbench
===================================

Name: cnet_reg_arbiter

Overview:
- Master side of the CPCI→CNET register bus, in the CPCI FPGA.
- Shares the single register bus between two requesters: port 0 is the PCI host register path, port 1 is the DMA/status poller.
- Arbitrates round-robin, sequences one bus transaction at a time with the CNET ready handshakes, and bounds every transaction with a timeout so a hung CNET cannot stall PCI.
- The tri-state driver for cpci_data sits at the top level, driven from cpci_data_out/cpci_data_oe.

Parameters:
- ADDR_WIDTH, 27, CPCI→CNET address width
- DATA_WIDTH, 32, register data width
- TIMEOUT_CYCLES, 255, max cycles waiting for a CNET ready before abort (1..65535)
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on a timeout

Ports:
- clk  in  1  system clock
- reset_L  in  1  asynchronous active-low reset
- req0 / req1  in  1  transaction request; held until matching ack
- rd_wr_L0 / rd_wr_L1  in  1  1=read, 0=write
- addr0 / addr1  in  ADDR_WIDTH  register address
- wr_data0 / wr_data1  in  DATA_WIDTH  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rd_data  out  DATA_WIDTH  read result, valid with ack
- err  out  1  timeout flag, valid with ack
- cpci_req  out  1  bus request strobe
- cpci_rd_wr_L  out  1  bus direction
- cpci_addr  out  ADDR_WIDTH  bus address
- cpci_data_out  out  DATA_WIDTH  write data to bus
- cpci_data_oe  out  1  enable for the top-level cpci_data tri-state
- cpci_data_in  in  DATA_WIDTH  bus read data
- cpci_wr_rdy  in  1  CNET can accept a write
- cpci_rd_rdy  in  1  CNET read data valid on cpci_data_in
- timeout_cnt  out  16  saturating timeout count (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert in the block's usage):
  - All outputs are 0, except cpci_rd_wr_L=1.
  - State=IDLE; last_grant=1, so port 0 wins the first tie.
- IDLE:
  - If any reqN, grant: a single requester wins; if both, the one ≠ last_grant wins.
  - Latch addr/rd_wr_L/wr_data of the winner into cpci_addr/cpci_rd_wr_L/cpci_data_out.
  - Update last_grant, clear the timer, go to WR_WAIT (write) or RD_ISSUE (read).
- WR_WAIT:
  - If cpci_wr_rdy=1: cpci_req=1 and cpci_data_oe=1 for exactly one cycle, then DONE.
  - Else the timer increments; at timer==TIMEOUT_CYCLES-1, go to DONE with err=1 and no strobe issued.
- RD_ISSUE: cpci_req=1 for one cycle, with cpci_data_oe=0; go to RD_WAIT.
- RD_WAIT:
  - If cpci_rd_rdy=1: capture cpci_data_in into rd_data, then DONE.
  - Else on timeout: rd_data=TIMEOUT_DATA, err=1, then DONE.
  - cpci_rd_rdy outside RD_WAIT is ignored.
- DONE:
  - ackN=1 for one cycle, for the granted port only; rd_data/err hold until the next DONE.
  - Next state is IDLE.
  - A requester that still holds req in the cycle after ack is treated as a new request.
- Latency and throughput:
  - Write with wr_rdy already high: req→ack = 3 cycles (IDLE, WR_WAIT, DONE).
  - Read with rd_rdy one cycle after the strobe: 4 cycles.
  - Maximum throughput is one transaction per 3 cycles.
- cpci_data_oe is never asserted in a read state, and never in the cycle next to a read strobe.
- reqN deasserted after grant: the transaction still completes and ack is still pulsed. Inputs are not re-sampled after grant.
- Timer width: clog2(TIMEOUT_CYCLES+1); no wrap, because the comparison exits the state.
- Reset mid-transaction: returns immediately to IDLE, with no ack and cpci_req/oe dropped asynchronously.

Optional Feature:
- Macro CNET_ARB_TIMEOUT_STATS_EN.
- Defined: timeout_cnt increments by 1 on each DONE with err=1 and saturates at 16'hFFFF. It is cleared only by reset.
- Undefined: timeout_cnt is tied to 0 and no counter logic is generated; port list unchanged.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE).
  - Default TIMEOUT_DATA.
  - Bus widths, aligned with the CPCI_CNET_ADDR_WIDTH/CPCI_CNET_DATA_WIDTH defines.
- One natural sub-module: cnet_rr_arb2, a 2-way round-robin grant with a last_grant register. The FSM and datapath stay in the top.

Test Plan:
- Write, port 0: addr=0x0000040, data=0x12345678, wr_rdy held 1 → cpci_req one cycle with oe=1; ack0 on cycle 3; err=0.
- Read, port 1: addr=0x0000100; rd_rdy pulses 2 cycles after the strobe with data 0xCAFEF00D → rd_data=0xCAFEF00D with ack1; err=0; oe never high.
- Contention: req0 and req1 both held for 4 transactions → grant order 0,1,0,1; no two strobes without an intervening DONE.
- Timeout: TIMEOUT_CYCLES=8, read with rd_rdy never asserted → ack after 8 RD_WAIT cycles; rd_data=0xDEADBEEF; err=1; with macro, timeout_cnt=1.
- Write stall: wr_rdy low for 5 cycles then high → no strobe while low; a single strobe on the first rdy cycle; ack next cycle.
- Reset mid-RD_WAIT: reset_L low → cpci_req/oe/ack immediately 0; after release, a fresh req0 is granted first.

Source files
------------

// File: rtl/cnet_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnet_reg_arbiter_pkg
// Description : Shared constants and types for the CPCI->CNET register bus
//               master: bus widths, default timeout read data and the
//               transaction sequencer state encoding.
//               Widths are aligned with the CPCI_CNET_ADDR_WIDTH /
//               CPCI_CNET_DATA_WIDTH system defines (27 / 32).
// Revision    : 1.0 - initial release
// ============================================================================
package cnet_reg_arbiter_pkg;

    localparam int CNET_ADDR_WIDTH = 27;
    localparam int CNET_DATA_WIDTH = 32;

    // Read data handed back when CNET never answers a read.
    localparam logic [31:0] CNET_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_WAIT  = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_DONE     = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/cnet_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : cnet_rr_arb2
// Description : Two-way round-robin grant. On a tie the port that did not
//               win last time is granted. The last-grant register only moves
//               when the caller advances (accepts the grant).
// Ports       : clk, reset_L (async active-low)
//               req0/req1  - requests
//               advance    - grant accepted this cycle
//               grant      - winning port index (valid when valid=1)
//               valid      - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module cnet_rr_arb2 (
    input  logic clk,
    input  logic reset_L,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic grant,
    output logic valid
);

    logic r_last_grant;

    assign valid = req0 | req1;
    // Lone requester wins outright; on a tie the other port from last time.
    assign grant = (req0 & req1) ? ~r_last_grant : req1;

    // Reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_last_grant <= 1'b1;
        end else if (advance && valid) begin
            r_last_grant <= grant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnet_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cnet_reg_arbiter
// Description : CPCI-side master of the CNET register bus. Arbitrates the PCI
//               host path (port 0) and the DMA/status poller (port 1)
//               round-robin, runs one bus transaction at a time against the
//               CNET write/read ready handshakes and aborts any transaction
//               whose ready does not arrive within TIMEOUT_CYCLES.
// Ports       : clk, reset_L (async active-low)
//               req/rd_wr_L/addr/wr_data 0,1 - requester side
//               ack0/ack1, rd_data, err        - completion (valid with ack)
//               cpci_req, cpci_rd_wr_L, cpci_addr, cpci_data_out,
//               cpci_data_oe, cpci_data_in, cpci_wr_rdy, cpci_rd_rdy - bus
//               timeout_cnt                    - saturating timeout count
// Options     : CNET_ARB_TIMEOUT_STATS_EN - enables timeout_cnt; when not
//               defined the port is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module cnet_reg_arbiter
    import cnet_reg_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = CNET_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = CNET_DATA_WIDTH,
    parameter int unsigned           TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(CNET_TIMEOUT_DATA)
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  rd_wr_L0,
    input  logic                  rd_wr_L1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wr_data0,
    input  logic [DATA_WIDTH-1:0] wr_data1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  err,
    output logic                  cpci_req,
    output logic                  cpci_rd_wr_L,
    output logic [ADDR_WIDTH-1:0] cpci_addr,
    output logic [DATA_WIDTH-1:0] cpci_data_out,
    output logic                  cpci_data_oe,
    input  logic [DATA_WIDTH-1:0] cpci_data_in,
    input  logic                  cpci_wr_rdy,
    input  logic                  cpci_rd_rdy,
    output logic [15:0]           timeout_cnt
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         r_state;
    logic               r_grant;
    logic [TIMER_W-1:0] r_timer;
    logic               r_rd_strobe;

    logic w_grant;
    logic w_grant_valid;
    logic w_sel_rd;
    logic w_timer_last;
    logic w_wr_strobe;

    cnet_rr_arb2 u_arb (
        .clk     (clk),
        .reset_L (reset_L),
        .req0    (req0),
        .req1    (req1),
        .advance (r_state == ST_IDLE),
        .grant   (w_grant),
        .valid   (w_grant_valid)
    );

    assign w_sel_rd     = w_grant ? rd_wr_L1 : rd_wr_L0;
    assign w_timer_last = (r_timer == TIMER_LAST);

    // The write strobe fires in the very cycle CNET shows wr_rdy, so it is
    // the registered state qualified by the ready input. Because r_state
    // resets asynchronously, the strobe and output enable drop with reset.
    assign w_wr_strobe  = (r_state == ST_WR_WAIT) && cpci_wr_rdy;
    assign cpci_req     = r_rd_strobe | w_wr_strobe;
    assign cpci_data_oe = w_wr_strobe;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state       <= ST_IDLE;
            r_grant       <= 1'b0;
            r_timer       <= '0;
            r_rd_strobe   <= 1'b0;
            cpci_rd_wr_L  <= 1'b1;
            cpci_addr     <= '0;
            cpci_data_out <= '0;
            rd_data       <= '0;
            err           <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
        end else begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            r_rd_strobe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_grant       <= w_grant;
                        r_timer       <= '0;
                        cpci_addr     <= w_grant ? addr1 : addr0;
                        cpci_data_out <= w_grant ? wr_data1 : wr_data0;
                        cpci_rd_wr_L  <= w_sel_rd;
                        if (w_sel_rd) begin
                            r_state     <= ST_RD_ISSUE;
                            r_rd_strobe <= 1'b1;
                        end else begin
                            r_state <= ST_WR_WAIT;
                        end
                    end
                end
                ST_WR_WAIT: begin
                    // Ready takes priority over an expiring timer.
                    if (cpci_wr_rdy) begin
                        r_state <= ST_DONE;
                        err     <= 1'b0;
                        ack0    <= ~r_grant;
                        ack1    <= r_grant;
                    end else if (w_timer_last) begin
                        r_state <= ST_DONE;
                        err     <= 1'b1;
                        ack0    <= ~r_grant;
                        ack1    <= r_grant;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_RD_ISSUE: begin
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (cpci_rd_rdy) begin
                        r_state <= ST_DONE;
                        rd_data <= cpci_data_in;
                        err     <= 1'b0;
                        ack0    <= ~r_grant;
                        ack1    <= r_grant;
                    end else if (w_timer_last) begin
                        r_state <= ST_DONE;
                        rd_data <= TIMEOUT_DATA;
                        err     <= 1'b1;
                        ack0    <= ~r_grant;
                        ack1    <= r_grant;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CNET_ARB_TIMEOUT_STATS_EN
    logic [15:0] r_timeout_cnt;

    // err is registered alongside the ack, so it is valid throughout DONE.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_timeout_cnt <= 16'h0000;
        end else if ((r_state == ST_DONE) && err && (r_timeout_cnt != 16'hFFFF)) begin
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end
    end

    assign timeout_cnt = r_timeout_cnt;
`else
    assign timeout_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnet_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnet_reg_arbiter
// Description : Self-checking bench for cnet_reg_arbiter (TIMEOUT_CYCLES=8).
//               Directed vector table, contention and reset-abort sequences,
//               then randomized rounds against a transaction-level model.
//               Honours CNET_ARB_TIMEOUT_STATS_EN for timeout_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnet_reg_arbiter;

    localparam int T = 8;

    logic        clk;
    logic        reset_L;
    logic        req0, req1, rd_wr_L0, rd_wr_L1;
    logic [26:0] addr0, addr1;
    logic [31:0] wr_data0, wr_data1;
    logic        ack0, ack1, err;
    logic [31:0] rd_data;
    logic        cpci_req, cpci_rd_wr_L, cpci_data_oe;
    logic [26:0] cpci_addr;
    logic [31:0] cpci_data_out, cpci_data_in;
    logic        cpci_wr_rdy, cpci_rd_rdy;
    logic [15:0] timeout_cnt;

    cnet_reg_arbiter #(
        .ADDR_WIDTH     (27),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .req0          (req0),
        .req1          (req1),
        .rd_wr_L0      (rd_wr_L0),
        .rd_wr_L1      (rd_wr_L1),
        .addr0         (addr0),
        .addr1         (addr1),
        .wr_data0      (wr_data0),
        .wr_data1      (wr_data1),
        .ack0          (ack0),
        .ack1          (ack1),
        .rd_data       (rd_data),
        .err           (err),
        .cpci_req      (cpci_req),
        .cpci_rd_wr_L  (cpci_rd_wr_L),
        .cpci_addr     (cpci_addr),
        .cpci_data_out (cpci_data_out),
        .cpci_data_oe  (cpci_data_oe),
        .cpci_data_in  (cpci_data_in),
        .cpci_wr_rdy   (cpci_wr_rdy),
        .cpci_rd_rdy   (cpci_rd_rdy),
        .timeout_cnt   (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Per-port pending transaction: read flag, address, write data,
    // read data CNET will return, and responder delay d.
    bit          prd  [2];
    logic [26:0] pa   [2];
    logic [31:0] pd   [2];
    logic [31:0] pdin [2];
    int          pdel [2];

    // Reference model state.
    int          m_last = 1;
    logic [15:0] m_tcnt = 16'h0000;

    typedef struct {
        bit          rd;
        int          port;
        logic [26:0] addr;
        logic [31:0] data;
        int          d;
        int          exp_done;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_tcnt();
`ifdef CNET_ARB_TIMEOUT_STATS_EN
        return m_tcnt;
`else
        return 16'h0000;
`endif
    endfunction

    // Round-robin rule: lone requester wins; on a tie, not the last winner.
    function automatic int m_pick(input bit p0, input bit p1);
        if (p0 && p1) return (m_last == 0) ? 1 : 0;
        return p1 ? 1 : 0;
    endfunction

    // Cycle (counted from the IDLE cycle that sees the request) holding ack.
    // Write: IDLE, d stalled WR_WAIT cycles, strobe cycle, DONE.
    // Read : IDLE, RD_ISSUE, d idle RD_WAIT cycles, ready cycle, DONE.
    // A delay of T or more means the timer runs out after T wait cycles.
    function automatic int m_done(input bit rd, input int d);
        if (d >= T) return rd ? T + 2 : T + 1;
        return rd ? d + 3 : d + 2;
    endfunction

    task automatic drive_ports(input bit p0, input bit p1);
        req0 = p0;         req1 = p1;
        rd_wr_L0 = prd[0]; rd_wr_L1 = prd[1];
        addr0 = pa[0];     addr1 = pa[1];
        wr_data0 = pd[0];  wr_data1 = pd[1];
    endtask

    task automatic check_reset_state();
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_cpci_req", cpci_req, 1'b0);
        check("rst_data_oe", cpci_data_oe, 1'b0);
        check("rst_rd_wr_L", cpci_rd_wr_L, 1'b1);
        check("rst_addr", cpci_addr, 32'h0);
        check("rst_data_out", cpci_data_out, 32'h0);
        check("rst_timeout_cnt", timeout_cnt, 16'h0);
    endtask

    // Run one transaction of port w while acting as the CNET responder.
    task automatic run_txn(input int w, input int exp_done, input bit exp_err,
                           input logic [31:0] exp_rd, input bit pend0, input bit pend1);
        logic exp_stb;
        int   d;
        bit   rd;
        d  = pdel[w];
        rd = prd[w];
        for (int c = 0; c <= exp_done; c++) begin
            @(posedge clk); #1;
            drive_ports(pend0, pend1);
            if (rd) begin
                cpci_wr_rdy  = 1'($urandom_range(0, 1));
                cpci_rd_rdy  = (c == 2 + d) || (c < 2 && $urandom_range(0, 1) == 1);
                cpci_data_in = (c == 2 + d) ? pdin[w] : $urandom;
            end else begin
                cpci_wr_rdy  = (c >= 1 + d);
                cpci_rd_rdy  = 1'($urandom_range(0, 1));
                cpci_data_in = $urandom;
            end
            @(negedge clk);
            exp_stb = rd ? (c == 1) : (d < T && c == 1 + d);
            check("strobe", cpci_req, exp_stb);
            check("data_oe", cpci_data_oe, !rd && exp_stb);
            check("ack0", ack0, c == exp_done && w == 0);
            check("ack1", ack1, c == exp_done && w == 1);
            if (c == 0) check("timeout_cnt", timeout_cnt, exp_tcnt());
            if (exp_stb) begin
                check("bus_addr", cpci_addr, pa[w]);
                check("bus_rd_wr_L", cpci_rd_wr_L, rd);
                if (!rd) check("bus_wdata", cpci_data_out, pd[w]);
            end
            if (c == exp_done) begin
                check("err", err, exp_err);
                if (rd) check("rd_data", rd_data, exp_rd);
            end
        end
        if (exp_err) m_tcnt++;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            drive_ports(1'b0, 1'b0);
            cpci_wr_rdy = 1'($urandom_range(0, 1));
            cpci_rd_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_strobe", cpci_req, 1'b0);
            check("idle_ack", {ack1, ack0}, 2'b00);
        end
    endtask

    // Start a port-0 transaction and hit reset in cycle at_c of it.
    task automatic abort_txn(input bit rd, input int at_c);
        prd[0]  = rd;
        pa[0]   = 27'h0ABCDEF;
        pd[0]   = 32'h5A5A_0F0F;
        pdel[0] = rd ? 99 : at_c - 1;
        m_last  = 0;
        for (int c = 0; c <= at_c; c++) begin
            @(posedge clk); #1;
            drive_ports(1'b1, 1'b0);
            cpci_wr_rdy = !rd && (c >= at_c);
            cpci_rd_rdy = 1'b0;
            @(negedge clk);
        end
        check("pre_abort_strobe", cpci_req, !rd);
        reset_L = 1'b0;
        #1;
        check("abort_cpci_req", cpci_req, 1'b0);
        check("abort_data_oe", cpci_data_oe, 1'b0);
        check("abort_ack", {ack1, ack0}, 2'b00);
        drive_ports(1'b0, 1'b0);
        cpci_wr_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        m_last  = 1;
        m_tcnt  = 16'h0000;
        check_reset_state();
    endtask

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  w;
        bit  p0, p1;
        int  pat;

        vecs[0] = '{0, 0, 27'h0000040, 32'h1234_5678, 0,  2,  0, 32'h0};
        vecs[1] = '{1, 1, 27'h0000100, 32'hCAFE_F00D, 1,  4,  0, 32'hCAFE_F00D};
        vecs[2] = '{1, 0, 27'h7FFFFFF, 32'h0BAD_F00D, 99, 10, 1, 32'hDEAD_BEEF};
        vecs[3] = '{0, 1, 27'h5555555, 32'hA5A5_A5A5, 5,  7,  0, 32'h0};
        vecs[4] = '{0, 0, 27'h0000001, 32'hFFFF_FFFF, 99, 9,  1, 32'h0};
        vecs[5] = '{1, 1, 27'h2AAAAAA, 32'h1357_9BDF, 0,  3,  0, 32'h1357_9BDF};
        vecs[6] = '{0, 1, 27'h0000000, 32'h0000_0000, 7,  9,  0, 32'h0};
        vecs[7] = '{1, 0, 27'h0000123, 32'h89AB_CDEF, 7,  10, 0, 32'h89AB_CDEF};
        vecs[8] = '{0, 1, 27'h0000777, 32'h0000_7777, 8,  9,  1, 32'h0};

        for (int p = 0; p < 2; p++) begin
            prd[p] = 1'b0; pa[p] = '0; pd[p] = '0; pdin[p] = '0; pdel[p] = 0;
        end
        reset_L = 1'b0;
        drive_ports(1'b0, 1'b0);
        cpci_wr_rdy = 1'b0; cpci_rd_rdy = 1'b0; cpci_data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        reset_L = 1'b1;

        // Directed vector table, one requester at a time.
        foreach (vecs[i]) begin
            w       = vecs[i].port;
            prd[w]  = vecs[i].rd;
            pa[w]   = vecs[i].addr;
            pd[w]   = vecs[i].data;
            pdin[w] = vecs[i].data;
            pdel[w] = vecs[i].d;
            m_last  = w;
            run_txn(w, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_rd,
                    w == 0, w == 1);
        end
        idle(2);

        // Reset during RD_WAIT, then a tie must go to port 0 first.
        abort_txn(1'b1, 2);
        for (int p = 0; p < 2; p++) begin
            prd[p] = 1'b0; pa[p] = 27'(32'h100 * (p + 1)); pd[p] = 32'hC0DE_0000 + p; pdel[p] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            w = m_pick(1'b1, 1'b1);
            check("rr_order", w, k % 2);
            m_last = w;
            run_txn(w, 2, 1'b0, 32'h0, 1'b1, 1'b1);
        end
        idle(1);

        // Reset while the write strobe is on the bus.
        abort_txn(1'b0, 3);

        // Randomized rounds against the model.
        for (int r = 0; r < 40; r++) begin
            for (int p = 0; p < 2; p++) begin
                prd[p]  = 1'($urandom_range(0, 1));
                pa[p]   = 27'($urandom);
                pd[p]   = $urandom;
                pdin[p] = $urandom;
                pdel[p] = $urandom_range(0, 10);
            end
            pat = $urandom_range(1, 3);
            p0  = (pat & 1) != 0;
            p1  = (pat & 2) != 0;
            while (p0 || p1) begin
                w = m_pick(p0, p1);
                m_last = w;
                run_txn(w, m_done(prd[w], pdel[w]), pdel[w] >= T,
                        (pdel[w] >= T) ? 32'hDEAD_BEEF : pdin[w], p0, p1);
                if (w == 0) p0 = 1'b0; else p1 = 1'b0;
            end
            idle($urandom_range(0, 2));
        end
        idle(1);
        check("final_timeout_cnt", timeout_cnt, exp_tcnt());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
